// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter sending back-to-back frames
//
// Ports:
//   clk100    in   1             system clock
//   reset     in   1             synchronous, active-high; flushes FIFO, aborts frame
//   wr_data   in   8             byte to enqueue
//   wr_en     in   1             enqueue strobe, sampled every clock edge
//   full      out  1             FIFO holds 2**DEPTH_LOG2 entries
//   level     out  DEPTH_LOG2+1  bytes queued, excluding the byte in flight
//   overflow  out  1             one-cycle pulse when a write is dropped while full
//   tx        out  1             serial line, idle high
//   busy      out  1             a frame is in progress or bytes are queued
module uart_tx_fifo #(
    parameter int RCONST     = 868,
    parameter int DEPTH_LOG2 = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk100,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  tx,
    output logic                  busy
);
    localparam int DEPTH    = 2 ** DEPTH_LOG2;
    localparam int STOP_LEN = STOP_BITS * RCONST;
    // The stop phase is the longest phase, so the counter is sized for it.
    localparam int CW       = $clog2(STOP_LEN);
    localparam logic [CW-1:0]         BIT_LAST  = CW'(RCONST - 1);
    localparam logic [CW-1:0]         STOP_LAST = CW'(STOP_LEN - 1);
    localparam logic [DEPTH_LOG2:0]   DEPTH_LV  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                r_state, w_state_n;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level, w_level_n;
    logic                  r_overflow, r_tx, w_tx_n;
    logic [7:0]            r_shift, w_shift_n, w_head;
    logic [CW-1:0]         r_cnt, w_cnt_n;
    logic [2:0]            r_bitn, w_bitn_n;
    logic                  w_full, w_push, w_pop, w_has_data, w_bit_end;

    assign w_full     = r_level == DEPTH_LV;
    assign w_push     = wr_en && !w_full;
    assign w_has_data = r_level != '0;
    assign w_bit_end  = r_cnt == BIT_LAST;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_level_n  = r_level + (DEPTH_LOG2 + 1)'(w_push) - (DEPTH_LOG2 + 1)'(w_pop);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_bitn_n  = r_bitn;
        w_shift_n = r_shift;
        w_tx_n    = r_tx;
        w_pop     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                w_tx_n  = 1'b1;
                if (w_has_data) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_head;
                    w_tx_n    = 1'b0;
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_n   = '0;
                    w_bitn_n  = '0;
                    w_tx_n    = r_shift[0];
                    w_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_n = '0;
                    if (r_bitn == 3'd7) begin
                        w_tx_n    = 1'b1;
                        w_state_n = S_STOP;
                    end else begin
                        // tx is registered, so the next bit is taken from shift[1]
                        // at the same edge the shift register moves right.
                        w_bitn_n  = r_bitn + 3'd1;
                        w_shift_n = r_shift >> 1;
                        w_tx_n    = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == STOP_LAST) begin
                    w_cnt_n = '0;
                    if (w_has_data) begin
                        // Chain straight into the next start bit with no idle cycle.
                        w_pop     = 1'b1;
                        w_shift_n = w_head;
                        w_tx_n    = 1'b0;
                        w_state_n = S_START;
                    end else begin
                        w_tx_n    = 1'b1;
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bitn     <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_level    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_bitn     <= w_bitn_n;
            r_shift    <= w_shift_n;
            r_tx       <= w_tx_n;
            r_level    <= w_level_n;
            r_overflow <= wr_en && w_full;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk100) begin
        if (!reset && w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign full     = w_full;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign tx       = r_tx;
    assign busy     = (r_state != S_IDLE) || w_has_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed check of uart_tx_fifo against a frame-schedule model
module tb_uart_tx_fifo;
    localparam int R     = 10;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int F     = 10 * R;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_en, full, overflow, tx, busy;
    logic [7:0]  wr_data;
    logic [DL:0] level;
    logic        rst2, wr2, full2, ovf2, tx2, busy2;
    logic [7:0]  wd2;
    logic [2:0]  level2;

    uart_tx_fifo #(.RCONST(R), .DEPTH_LOG2(DL), .STOP_BITS(1)) dut (
        .clk100(clk), .reset(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full),
        .level(level), .overflow(overflow), .tx(tx), .busy(busy)
    );

    uart_tx_fifo #(.RCONST(R), .DEPTH_LOG2(2), .STOP_BITS(2)) dut2 (
        .clk100(clk), .reset(rst2), .wr_data(wd2), .wr_en(wr2), .full(full2),
        .level(level2), .overflow(ovf2), .tx(tx2), .busy(busy2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of accepted bytes plus the start edge of the frame
    // on the wire. A frame starts one edge after its byte is queued, or exactly
    // F edges after the previous frame started, whichever is later.
    logic [7:0] mq[$];
    logic [7:0] cur_data;
    int         cur_start = 0;
    bit         cur_valid = 0;
    int         e = 0;
    int         j;
    int         n_ovf = 0;
    bit         pre_full, in_frame;
    logic       exp_tx, exp_ovf = 1'b0, exp_busy;

    always @(posedge clk) begin
        e++;
        if (rst) begin
            mq.delete();
            cur_valid = 0;
            exp_ovf = 1'b0;
        end else begin
            pre_full = mq.size() == DEPTH;
            exp_ovf = wr_en && pre_full;
            if (mq.size() != 0 && (!cur_valid || e >= cur_start + F)) begin
                cur_data = mq.pop_front();
                cur_start = e;
                cur_valid = 1;
            end
            if (wr_en && !pre_full) mq.push_back(wr_data);
        end
        in_frame = cur_valid && e < cur_start + F;
        j = in_frame ? (e - cur_start) / R : 9;
        exp_tx = 1'b1;
        if (j == 0) exp_tx = 1'b0;
        else if (j <= 8) exp_tx = cur_data[j-1];
        exp_busy = in_frame || mq.size() != 0;
        #1;
        check("tx", tx, exp_tx);
        check("level", level, mq.size());
        check("full", full, mq.size() == DEPTH);
        check("overflow", overflow, exp_ovf);
        check("busy", busy, exp_busy);
        if (overflow === 1'b1) n_ovf++;
    end

    task automatic drive(input logic en, input logic [7:0] d);
        @(negedge clk);
        wr_en = en;
        wr_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
    endtask

    logic cap_tx[240], cap_bz[240];
    int   cap_lv[240];
    int   base, ones;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        rst2 = 1'b1; wr2 = 1'b0; wd2 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0; rst2 = 1'b0;
        idle(3);

        // Single 0x55 frame: start bit one edge after the write edge.
        drive(1'b1, 8'h55);
        for (int k = 0; k < 105; k++) begin
            @(negedge clk);
            wr_en = 1'b0;
            cap_tx[k] = tx; cap_bz[k] = busy; cap_lv[k] = level;
        end
        check("t1_lv0", cap_lv[0], 1);
        check("t1_lv1", cap_lv[1], 0);
        check("t1_idle", cap_tx[0], 1);
        check("t1_start", cap_tx[1], 0);
        check("t1_start_end", cap_tx[10], 0);
        check("t1_b0", cap_tx[11], 1);
        check("t1_b1", cap_tx[21], 0);
        check("t1_b6", cap_tx[80], 1);
        check("t1_b7", cap_tx[81], 0);
        check("t1_stop", cap_tx[91], 1);
        check("t1_busy_last", cap_bz[100], 1);
        check("t1_busy_drop", cap_bz[101], 0);

        // Three-byte burst; the model checks contiguity cycle by cycle.
        drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'hA5);
        idle(320);

        // 18 back-to-back writes: one popped, 16 stored, one dropped.
        base = n_ovf;
        for (int k = 0; k < 18; k++) drive(1'b1, 8'($urandom));
        idle(2);
        check("t3_ovf_count", n_ovf - base, 1);
        check("t3_full", full, 1);
        check("t3_level", level, 16);
        idle(1750);

        // Reset mid-frame with five bytes queued.
        for (int k = 0; k < 6; k++) drive(1'b1, 8'($urandom));
        idle(32);
        @(negedge clk); rst = 1'b1; wr_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        check("t4_tx", tx, 1);
        check("t4_level", level, 0);
        check("t4_busy", busy, 0);
        idle(150);
        check("t4_quiet_tx", tx, 1);
        check("t4_quiet_busy", busy, 0);

        // Random traffic: sparse writes, dense bursts and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            wr_en = (k % 1000 < 200) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 99) < 6);
            wr_data = 8'($urandom);
        end
        @(negedge clk); rst = 1'b0;
        idle(1800);

        // Two stop bits: 110-cycle frames, 20 high cycles before the second start.
        @(negedge clk); wr2 = 1'b1; wd2 = 8'h00;
        for (int k = 0; k < 230; k++) begin
            @(negedge clk);
            if (k == 0) wd2 = 8'h3C; else wr2 = 1'b0;
            cap_tx[k] = tx2; cap_bz[k] = busy2; cap_lv[k] = level2;
        end
        ones = 0;
        for (int k = 91; k <= 110; k++) ones += int'(cap_tx[k]);
        check("t5_lv0", cap_lv[0], 1);
        check("t5_lv1", cap_lv[1], 1);
        check("t5_lv110", cap_lv[110], 1);
        check("t5_lv112", cap_lv[112], 0);
        check("t5_start1", cap_tx[1], 0);
        check("t5_b7_first", cap_tx[90], 0);
        check("t5_stop_ones", ones, 20);
        check("t5_start2", cap_tx[111], 0);
        check("t5_b2_second", cap_tx[141], 1);
        check("t5_b7_second", cap_tx[200], 0);
        check("t5_stop2", cap_tx[201], 1);
        check("t5_busy_last", cap_bz[220], 1);
        check("t5_busy_drop", cap_bz[221], 0);
        check("t5_idle_tx", cap_tx[225], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
